// File: rtl/moore_seq_detector_param.sv
// Programmable serial pattern detector with Moore-registered match pulse,
// input qualification, selectable overlap and a saturating match counter.
module moore_seq_detector_param #(
  parameter int                   PAT_WIDTH       = 4,
  parameter logic [PAT_WIDTH-1:0] DEFAULT_PATTERN = 4'b1011,
  parameter int                   CNT_WIDTH       = 8,
  localparam int                  LEN_W           = $clog2(PAT_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 x,
  input  logic                 x_valid,
  input  logic                 cfg_load,
  input  logic [PAT_WIDTH-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 overlap_en,
  input  logic                 cnt_clr,
  output logic                 z,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic                 cnt_sat
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_WIDTH);

  logic [PAT_WIDTH-1:0] hist, hist_nxt, hist_shift;
  logic [PAT_WIDTH-1:0] pat, pat_nxt;
  logic [PAT_WIDTH-1:0] len_mask;
  logic [LEN_W-1:0]     fill, fill_nxt, fill_inc;
  logic [LEN_W-1:0]     len, len_nxt;
  logic [LEN_W:0]       fill_sum;
  logic                 match;
  logic                 z_nxt;
  logic [CNT_WIDTH-1:0] cnt_nxt;
  logic                 sat_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      hist        <= '0;
      fill        <= '0;
      pat         <= DEFAULT_PATTERN;
      len         <= LEN_MAX;
      z           <= 1'b0;
      match_count <= '0;
      cnt_sat     <= 1'b0;
    end else begin
      hist        <= hist_nxt;
      fill        <= fill_nxt;
      pat         <= pat_nxt;
      len         <= len_nxt;
      z           <= z_nxt;
      match_count <= cnt_nxt;
      cnt_sat     <= sat_nxt;
    end
  end

  always_comb begin
    hist_shift = {hist[PAT_WIDTH-2:0], x};
    fill_sum   = {1'b0, fill} + (LEN_W + 1)'(1);
    fill_inc   = (fill_sum > {1'b0, len}) ? len : fill_sum[LEN_W-1:0];
    for (int i = 0; i < PAT_WIDTH; i++) begin
      len_mask[i] = (i < int'(len));
    end
    // Only the low len bits of history/pattern take part in the compare.
    match = x_valid && !cfg_load && (fill_inc == len) &&
            (((hist_shift ^ pat) & len_mask) == '0);

    hist_nxt = hist;
    fill_nxt = fill;
    pat_nxt  = pat;
    len_nxt  = len;
    z_nxt    = 1'b0;
    cnt_nxt  = match_count;

    if (cfg_load) begin
      pat_nxt  = cfg_pattern;
      len_nxt  = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (x_valid) begin
      hist_nxt = hist_shift;
      fill_nxt = (match && !overlap_en) ? '0 : fill_inc;
      z_nxt    = match;
    end

    if (cnt_clr) begin
      cnt_nxt = '0;
    end else if (match && !(&match_count)) begin
      cnt_nxt = match_count + CNT_WIDTH'(1);
    end
    sat_nxt = &cnt_nxt;
  end

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Scoreboard bench: stimulus queues expected match events, a negedge monitor
// checks each z pulse (cycle, counts, saturation) on an 8-bit and a 2-bit counter build.
module tb_moore_seq_detector_param;

  typedef struct {
    int   cyc;
    int   c8;
    int   c2;
    logic s2;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic       x_valid = 1'b0;
  logic       cfg_load = 1'b0;
  logic [3:0] cfg_pattern = 4'b0000;
  logic [2:0] cfg_len = 3'd0;
  logic       overlap_en = 1'b1;
  logic       cnt_clr = 1'b0;

  logic       z, z2;
  logic [7:0] match_count;
  logic [1:0] mc2;
  logic       sat, sat2;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   c8 = 0;
  int   c2 = 0;
  exp_t q[$];

  moore_seq_detector_param #(.PAT_WIDTH(4), .DEFAULT_PATTERN(4'b1011), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .overlap_en(overlap_en),
    .cnt_clr(cnt_clr), .z(z), .match_count(match_count), .cnt_sat(sat)
  );

  moore_seq_detector_param #(.PAT_WIDTH(4), .DEFAULT_PATTERN(4'b1011), .CNT_WIDTH(2)) dut_w2 (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .overlap_en(overlap_en),
    .cnt_clr(cnt_clr), .z(z2), .match_count(mc2), .cnt_sat(sat2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every z pulse must correspond to the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (z || z2) begin
      if (q.size() == 0) begin
        check("unexpected_z", int'(z) + int'(z2), 0);
      end else begin
        e = q.pop_front();
        check("z_cycle", cyc, e.cyc);
        check("z", int'(z), 1);
        check("z_w2", int'(z2), 1);
        check("match_count", int'(match_count), e.c8);
        check("match_count_w2", int'(mc2), e.c2);
        check("cnt_sat_w2", int'(sat2), int'(e.s2));
        check("cnt_sat", int'(sat), 0);
      end
    end
  end

  task automatic step(input logic xv, input logic xb, input logic m, input logic clr);
    x_valid = xv;
    x       = xb;
    cnt_clr = clr;
    if (clr) begin
      c8 = 0;
      c2 = 0;
    end else if (m) begin
      if (c8 < 255) c8++;
      if (c2 < 3) c2++;
    end
    if (m) q.push_back('{cyc + 1, c8, c2, (c2 == 3)});
    @(negedge clk);
    cnt_clr = 1'b0;
    x_valid = 1'b0;
  endtask

  // s and m list bits oldest-first from the MSB of the n-bit field.
  task automatic run(input logic [31:0] s, input logic [31:0] m, input int n,
                     input int gap, input logic clr_last);
    for (int i = 0; i < n; i++) begin
      step(1'b1, s[n-1-i], m[n-1-i], clr_last && (i == n - 1));
      repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    x_valid = 1'b1;
    x       = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    x_valid = 1'b0;
    x       = 1'b0;
    c8 = 0;
    c2 = 0;
  endtask

  task automatic load(input logic [3:0] p, input logic [2:0] l, input logic xv, input logic xb);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    x_valid     = xv;
    x           = xb;
    @(negedge clk);
    cfg_load = 1'b0;
    x_valid  = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    check(name, q.size(), 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    check("rst_z", int'(z), 0);
    check("rst_match_count", int'(match_count), 0);
    check("rst_cnt_sat", int'(sat), 0);
    check("rst_match_count_w2", int'(mc2), 0);
    check("rst_cnt_sat_w2", int'(sat2), 0);

    // Default 1011, overlapping: pulses after bits 6, 9, 15.
    overlap_en = 1'b1;
    run(32'b0010110110010110, 32'b0000010010000010, 16, 0, 1'b0);
    drain("pending_overlap");
    check("count_overlap", int'(match_count), 3);
    check("sat_w2_overlap", int'(sat2), 1);

    // Reset after a partial 1,0,1 (reset cycle also offers a completing bit).
    run(32'b101, 32'b000, 3, 0, 1'b0);
    do_reset();
    check("midrst_z", int'(z), 0);
    check("midrst_match_count", int'(match_count), 0);
    check("midrst_match_count_w2", int'(mc2), 0);
    check("midrst_cnt_sat_w2", int'(sat2), 0);
    run(32'b1, 32'b0, 1, 0, 1'b0);
    run(32'b1011, 32'b0001, 4, 0, 1'b0);
    drain("pending_midrst");
    check("count_midrst", int'(match_count), 1);

    // Same stream, non-overlapping: pulses after bits 6 and 15 only.
    do_reset();
    overlap_en = 1'b0;
    run(32'b0010110110010110, 32'b0000010000000010, 16, 0, 1'b0);
    drain("pending_nonoverlap");
    check("count_nonoverlap", int'(match_count), 2);

    // Pattern 110 (len 3) with two idle cycles after each bit.
    do_reset();
    overlap_en = 1'b1;
    load(4'b0110, 3'd3, 1'b0, 1'b0);
    run(32'b110110, 32'b001001, 6, 2, 1'b0);
    drain("pending_gaps");
    check("count_gaps", int'(match_count), 2);

    // cfg_load drops a coincident sample and flushes; len 0 clamps to 4.
    do_reset();
    run(32'b101, 32'b000, 3, 0, 1'b0);
    load(4'b1011, 3'd0, 1'b1, 1'b1);
    run(32'b1011, 32'b0001, 4, 0, 1'b0);
    drain("pending_cfgload");
    check("count_cfgload", int'(match_count), 1);

    // Saturation on the 2-bit build, then cnt_clr coincident with a match.
    do_reset();
    overlap_en = 1'b0;
    repeat (5) run(32'b1011, 32'b0001, 4, 0, 1'b0);
    drain("pending_sat");
    check("count_sat_w8", int'(match_count), 5);
    check("count_sat_w2", int'(mc2), 3);
    check("cnt_sat_w2_hold", int'(sat2), 1);
    run(32'b1011, 32'b0001, 4, 0, 1'b1);
    drain("pending_clr");
    check("count_clr_w8", int'(match_count), 0);
    check("count_clr_w2", int'(mc2), 0);
    check("cnt_sat_w2_clr", int'(sat2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
